// File: rtl/mem_access_unit.sv
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store unit between the memory stage and the data bus.
//               Captures one op at a time, drives a registered bus request,
//               and returns the formatted (shifted and extended) load data
//               as a single-cycle response pulse. Upstream stages are
//               frozen through `stall` while a bus access is in flight.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option:
//   MAU_MISALIGN_TRAP_EN  defined   : misaligned ops skip the bus and complete
//                                     with misalign = 1, rsp_rdata = 0.
//                         undefined : misalign is always 0; the address is
//                                     forced to natural alignment and the
//                                     oversize requests are clamped.
// ----------------------------------------------------------------------------
// Ports:
//   clk, reset (async, active low)
//   req_*       memory-stage op in (valid/ready, write, size, unsigned,
//               addr, wdata), flush
//   stall       freeze upstream stages
//   rsp_*       completion pulse, extended load data, misalign flag
//   dreq_*      registered bus request (valid, addr, size, strobe, data)
//   dresp_*     bus completion and raw read data
// ============================================================================
`default_nettype none

module mem_access_unit #(
    parameter int DATA_W = 64,          // 32 or 64
    parameter int ADDR_W = 64,
    parameter int STRB_W = DATA_W / 8   // derived, leave at default
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              flush,
    output logic              stall,

    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              misalign,

    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [2:0]        dreq_size,
    output logic [STRB_W-1:0] dreq_strobe,
    output logic [DATA_W-1:0] dreq_data,
    input  logic              dresp_data_ok,
    input  logic [DATA_W-1:0] dresp_data
);

    // Byte-offset width within one bus beat, and the largest natural size.
    localparam int         OFF_W  = $clog2(STRB_W);
    localparam logic [1:0] MAX_SZ = 2'(OFF_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State and captured-op registers
    // ------------------------------------------------------------------------
    state_t              state_q,       state_d;
    logic                write_q,       write_d;
    logic                unsigned_q,    unsigned_d;
    logic [1:0]          size_q,        size_d;
    logic [OFF_W-1:0]    off_q,         off_d;
    logic                flush_q,       flush_d;

    logic                rsp_valid_q,   rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q,   rsp_rdata_d;
    logic                misalign_q,    misalign_d;

    logic                dreq_valid_q,  dreq_valid_d;
    logic [ADDR_W-1:0]   dreq_addr_q,   dreq_addr_d;
    logic [2:0]          dreq_size_q,   dreq_size_d;
    logic [STRB_W-1:0]   dreq_strobe_q, dreq_strobe_d;
    logic [DATA_W-1:0]   dreq_data_q,   dreq_data_d;

    // ------------------------------------------------------------------------
    // Request-side formatting (evaluated on the incoming op)
    // ------------------------------------------------------------------------
    logic [1:0]          w_sz_eff;
    logic [OFF_W-1:0]    w_sz_mask;
    logic [ADDR_W-1:0]   w_addr_al;
    logic [OFF_W-1:0]    w_off;
    logic [STRB_W-1:0]   w_strb_base;
    logic [STRB_W-1:0]   w_strb;
    logic [DATA_W-1:0]   w_wdata;
`ifdef MAU_MISALIGN_TRAP_EN
    logic                w_misalign;
`endif

    always_comb begin
        // Oversize requests are clamped to a full beat; in trap mode they
        // are flagged as misaligned below before this value matters.
        w_sz_eff    = (req_size > MAX_SZ) ? MAX_SZ : req_size;
        w_sz_mask   = OFF_W'((32'd1 << w_sz_eff) - 32'd1);
        // Clearing the low size bits is a no-op for an aligned address, so
        // the same path serves both build options.
        w_addr_al   = req_addr & ~ADDR_W'((32'd1 << w_sz_eff) - 32'd1);
        w_off       = w_addr_al[OFF_W-1:0];
        w_strb_base = {STRB_W{1'b1}} >> (STRB_W - (1 << w_sz_eff));
        w_strb      = w_strb_base << w_off;
        w_wdata     = req_wdata << {w_off, 3'b000};
`ifdef MAU_MISALIGN_TRAP_EN
        w_misalign  = (req_size > MAX_SZ) || ((req_addr[OFF_W-1:0] & w_sz_mask) != '0);
`endif
    end

    // ------------------------------------------------------------------------
    // Response-side formatting (uses the captured size/offset)
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0]   w_shifted;
    logic [DATA_W-1:0]   w_fmask;
    logic                w_sign;
    logic [DATA_W-1:0]   w_load;

    always_comb begin
        w_shifted = dresp_data >> {off_q, 3'b000};
        // Field mask covering the access width; all ones for a full beat,
        // which makes the extension step a pass-through in that case.
        w_fmask   = {DATA_W{1'b1}} >> (DATA_W - (8 << size_q));
        // Top bit of the field: the mask bit that is not in mask >> 1.
        w_sign    = |(w_shifted & (w_fmask ^ (w_fmask >> 1)));
        w_load    = (w_shifted & w_fmask) |
                    ((w_sign && !unsigned_q) ? ~w_fmask : '0);
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        unsigned_d    = unsigned_q;
        size_d        = size_q;
        off_d         = off_q;
        flush_d       = flush_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        misalign_d    = misalign_q;
        dreq_valid_d  = dreq_valid_q;
        dreq_addr_d   = dreq_addr_q;
        dreq_size_d   = dreq_size_q;
        dreq_strobe_d = dreq_strobe_q;
        dreq_data_d   = dreq_data_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d    = req_write;
                    unsigned_d = req_unsigned;
                    size_d     = w_sz_eff;
                    off_d      = w_off;
                    flush_d    = 1'b0;
`ifdef MAU_MISALIGN_TRAP_EN
                    if (w_misalign) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        misalign_d  = 1'b1;
                    end else
`endif
                    begin
                        state_d       = ST_REQ;
                        dreq_valid_d  = 1'b1;
                        dreq_addr_d   = w_addr_al;
                        dreq_size_d   = {1'b0, w_sz_eff};
                        dreq_strobe_d = req_write ? w_strb  : '0;
                        dreq_data_d   = req_write ? w_wdata : '0;
                    end
                end
            end

            ST_REQ: begin
                // A flush only marks the op; the bus access still completes.
                if (flush) begin
                    flush_d = 1'b1;
                end
                if (dresp_data_ok) begin
                    state_d       = ST_RESP;
                    rsp_valid_d   = !(flush_q || flush);
                    rsp_rdata_d   = write_q ? '0 : w_load;
                    misalign_d    = 1'b0;
                    dreq_valid_d  = 1'b0;
                    dreq_addr_d   = '0;
                    dreq_size_d   = '0;
                    dreq_strobe_d = '0;
                    dreq_data_d   = '0;
                end
            end

            ST_RESP: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
                rsp_rdata_d = '0;
                misalign_d  = 1'b0;
                flush_d     = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            write_q       <= 1'b0;
            unsigned_q    <= 1'b0;
            size_q        <= '0;
            off_q         <= '0;
            flush_q       <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            misalign_q    <= 1'b0;
            dreq_valid_q  <= 1'b0;
            dreq_addr_q   <= '0;
            dreq_size_q   <= '0;
            dreq_strobe_q <= '0;
            dreq_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            write_q       <= write_d;
            unsigned_q    <= unsigned_d;
            size_q        <= size_d;
            off_q         <= off_d;
            flush_q       <= flush_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            misalign_q    <= misalign_d;
            dreq_valid_q  <= dreq_valid_d;
            dreq_addr_q   <= dreq_addr_d;
            dreq_size_q   <= dreq_size_d;
            dreq_strobe_q <= dreq_strobe_d;
            dreq_data_q   <= dreq_data_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign req_ready   = (state_q == ST_IDLE);
    // Gated by reset so every output other than req_ready reads 0 while
    // reset is held, even with an op presented.
    assign stall       = reset && ((state_q == ST_REQ) ||
                                   ((state_q == ST_IDLE) && req_valid));
    // A flush seen during the response cycle still drops the pulse.
    assign rsp_valid   = rsp_valid_q && !flush;
    assign rsp_rdata   = rsp_rdata_q;
    assign misalign    = misalign_q;
    assign dreq_valid  = dreq_valid_q;
    assign dreq_addr   = dreq_addr_q;
    assign dreq_size   = dreq_size_q;
    assign dreq_strobe = dreq_strobe_q;
    assign dreq_data   = dreq_data_q;

endmodule

`default_nettype wire
